// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the FP execute path (adder and multiplier).
//   state_t    : sequencing states of the multi-cycle adder
//   FP_*       : IEEE-754 single-precision field widths and limits
//   WORK_W     : working mantissa width {hidden, mant[22:0], 3 guard bits}
package fp_pkg;
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    localparam int FP_EXP_W   = 8;
    localparam int FP_MANT_W  = 23;
    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;
    localparam int WORK_W     = 27;
endpackage

// File: rtl/fp_add_seq32.sv
// fp_add_seq32: multi-cycle single-precision add/subtract.
// Alignment and normalization each shift one bit per cycle.
// The numeric model is simplified: truncation, flush-to-zero, no NaN/Inf/denormal.
//   clk, reset : clock and asynchronous active-high reset
//   start      : request, sampled only while idle
//   a, b, sub  : operands; sub=1 computes a - b
//   busy       : high whenever the state is not IDLE
//   done       : one-cycle pulse when result is updated
//   result     : registered result, held until the next completion
module fp_add_seq32
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    state_t                state;
    logic                  sign_l, sign_s;
    logic [FP_EXP_W-1:0]   exp_l, exp_w;
    logic [WORK_W-1:0]     man_l, man_s;
    logic [4:0]            cnt;
    logic [WORK_W:0]       mag;

    // Capture-time operand ordering: L gets the larger {exp, mant}
    logic [31:0]           op_b, op_l, op_s;
    logic [FP_EXP_W-1:0]   diff;
    logic [WORK_W-1:0]     cap_ml, cap_ms;
    logic [4:0]            cap_d;
    logic [WORK_W:0]       sum;

    always_comb begin
        op_b = {b[31] ^ sub, b[30:0]};
        if (a[30:0] >= op_b[30:0]) begin
            op_l = a;
            op_s = op_b;
        end else begin
            op_l = op_b;
            op_s = a;
        end
        // Exponent 0 is exact zero: the whole mantissa is discarded
        cap_ml = (op_l[30:23] != 8'd0) ? {1'b1, op_l[22:0], 3'b000} : '0;
        cap_ms = (op_s[30:23] != 8'd0) ? {1'b1, op_s[22:0], 3'b000} : '0;
        diff   = op_l[30:23] - op_s[30:23];
        cap_d  = diff[4:0];
        if (op_s[30:23] == 8'd0) begin
            cap_d = 5'd0;
        end else if (diff > 8'd26) begin
            // S would be shifted out entirely; skip the alignment cycles
            cap_ms = '0;
            cap_d  = 5'd0;
        end
    end

    // L - S never goes negative because L was chosen by magnitude
    always_comb begin
        if (sign_l == sign_s) sum = {1'b0, man_l} + {1'b0, man_s};
        else                  sum = {1'b0, man_l} - {1'b0, man_s};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sign_l <= 1'b0;
            sign_s <= 1'b0;
            exp_l  <= '0;
            exp_w  <= '0;
            man_l  <= '0;
            man_s  <= '0;
            cnt    <= '0;
            mag    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sign_l <= op_l[31];
                    sign_s <= op_s[31];
                    exp_l  <= op_l[30:23];
                    man_l  <= cap_ml;
                    man_s  <= cap_ms;
                    cnt    <= cap_d;
                    state  <= ALIGN;
                end
                ALIGN: begin
                    if (cnt == 5'd0) begin
                        state <= ADD;
                    end else begin
                        man_s <= man_s >> 1;
                        cnt   <= cnt - 5'd1;
                    end
                end
                ADD: begin
                    if (sum == '0) begin
                        result <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        mag   <= sum;
                        exp_w <= exp_l;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag[WORK_W]) begin
                        if (exp_w == 8'(FP_EXP_MAX - 1)) begin
                            result <= '0;          // overflow flush
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            mag   <= {1'b0, mag[WORK_W:1]};
                            exp_w <= exp_w + 8'd1;
                        end
                    end else if (!mag[WORK_W-1]) begin
                        if (exp_w == 8'd1) begin
                            result <= '0;          // underflow flush
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            mag   <= {mag[WORK_W-1:0], 1'b0};
                            exp_w <= exp_w - 8'd1;
                        end
                    end else begin
                        result <= {sign_l, exp_w, mag[25:3]};
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
